neureka_normquant_shift_pack: RTL
=================================

// Module: neureka_normquant_shift_pack
// PURPOSE
//  Stage directly downstream of the normquant multiplier: consumes signed products, applies
//  per-layer arithmetic right shift, optional rounding, and clipping to OUT_BITS.
//  Packs PACK quantized results into one output word with byte strobes for the streamer.
//  Valid/ready on both sides; one product accepted per cycle at full throughput.
// PARAMETERS
//  NMS       neureka_package::NORM_MULT_SIZE      norm multiplier magnitude width
//  ACC       neureka_package::NEUREKA_ACCUM_SIZE  accumulator width; product width = NMS+ACC
//  OUT_BITS  8                                    quantized element width
//  PACK      4                                    elements per output word (power of 2, >=2)
// PORTS
//  clk_i         in   1               clock
//  rst_ni        in   1               reset, asynchronous, active-low
//  clear_i       in   1               synchronous clear of all state
//  shift_i       in   5               right-shift amount, 0..31, static during a layer
//  signed_out_i  in   1               1: signed clip; 0: unsigned (ReLU) clip
//  prod_valid_i  in   1               product beat valid
//  prod_ready_o  out  1               product beat accepted when valid & ready
//  product_i     in   NMS+ACC         signed product from multiplier stage
//  last_i        in   1               beat is last of stream; flushes partial word
//  word_valid_o  out  1               packed word valid
//  word_ready_i  in   1               downstream accepts word
//  word_data_o   out  PACK*OUT_BITS   packed word, lane 0 in LSBs
//  word_strb_o   out  PACK            lane-written mask
// BEHAVIOUR
//  - Reset/clear: word_valid_o=0, word_data_o=0, word_strb_o=0, lane counter=0, pack buffer=0.
//    clear_i has priority over every other event in the same cycle; in-flight word is dropped.
//  - prod_ready_o = ~word_valid_o | word_ready_i (combinational from word_ready_i, allowed).
//  - Quantize (combinational on accepted beat): ext = sign-extend product_i to NMS+ACC+1 bits;
//    [+ rounding term, see CONFIGURATION]; sh = ext >>> shift_i (arithmetic).
//  - Clip: signed_out_i=1 -> saturate to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1];
//    signed_out_i=0 -> saturate to [0, 2^OUT_BITS-1]; result is low OUT_BITS bits.
//  - Packing: lane counter cnt (log2 PACK bits). Accepted beat writes lane cnt of buffer and
//    sets strobe bit cnt. If cnt==PACK-1 or last_i: buffer+strobe (incl. this lane) move to
//    output register, word_valid_o=1 next cycle, buffer/strobes cleared, cnt=0; else cnt++.
//  - Latency: word_valid_o rises the cycle after the completing beat is accepted.
//  - Unwritten lanes of a partial word are 0, their strobes 0.
//  - Hold: while word_valid_o & ~word_ready_i, word_data_o/word_strb_o stable; no beat accepted.
//  - word_valid_o & word_ready_i with a completing beat same cycle: new word loaded,
//    word_valid_o stays 1 (back-to-back, no bubble). Without a completing beat: falls to 0.
//  - shift_i/signed_out_i changes mid-word affect only subsequently accepted beats.
// CONFIGURATION
//  - Macro NEUREKA_NQ_ROUND_EN defined: when shift_i>0, add 2^(shift_i-1) to ext before
//    shifting (round-half-up); addition in NMS+ACC+1 bits, never overflows.
//  - Undefined: no rounding term, pure truncation toward -inf; rounding logic absent.
// TESTING
//  1. unsigned, shift=8, beats 0x100,0x200,0x300,0x400 back-to-back, word_ready_i=1 ->
//     1 cycle after 4th: word_data_o=0x04030201, strb=0xF, valid for exactly 1 cycle.
//  2. shift=0: signed beats -70000,70000 -> lanes 0x80,0x7F; unsigned beats -5,300 ->
//     lanes 0x00,0xFF; last_i on 4th -> word 0xFF007F80, strb=0xF.
//  3. last_i on 2nd beat (0x1,0x2, shift=0) -> word 0x00000201, strb=0x3; next beat
//     lands in lane 0 of a new word.
//  4. word_ready_i=0 for 5 cycles with word pending -> word_valid_o=1, data stable,
//     prod_ready_o=0; release with completing beat waiting -> no bubble between words.
//  5. product 0x180, shift=8: with NEUREKA_NQ_ROUND_EN -> 0x02; without -> 0x01;
//     product -0x180 signed: with -> 0xFF (-1), without -> 0xFE (-2).
//  6. clear_i after 2 beats, then rst_ni pulsed mid-word in a second run -> outputs 0,
//     next 4 beats form a full word starting at lane 0, strb=0xF.

Source files
------------

// File: rtl/neureka_normquant_shift_pack.sv
// Normquant back end: shifts and clips signed products, then packs PACK results per output word.
// Build option NEUREKA_NQ_ROUND_EN adds round-half-up before the shift; without it, truncates.
module neureka_normquant_shift_pack #(
  parameter int unsigned NMS      = 8,
  parameter int unsigned ACC      = 32,
  parameter int unsigned OUT_BITS = 8,
  parameter int unsigned PACK     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [4:0]                 shift_i,
  input  logic                       signed_out_i,
  input  logic                       prod_valid_i,
  output logic                       prod_ready_o,
  input  logic [NMS+ACC-1:0]         product_i,
  input  logic                       last_i,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic [PACK*OUT_BITS-1:0]   word_data_o,
  output logic [PACK-1:0]            word_strb_o
);

  localparam int unsigned PW    = NMS + ACC;
  localparam int unsigned EW    = PW + 1;
  localparam int unsigned CntW  = $clog2(PACK);
  localparam int unsigned WordW = PACK * OUT_BITS;

  localparam logic signed [EW-1:0] SMax =
    signed'({{(EW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}});
  localparam logic signed [EW-1:0] SMin =
    signed'({{(EW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}});
  localparam logic signed [EW-1:0] UMax =
    signed'({{(EW-OUT_BITS){1'b0}}, {OUT_BITS{1'b1}}});

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WordW-1:0]      buf_q, buf_d;
  logic [PACK-1:0]       strb_q, strb_d;
  logic [WordW-1:0]      word_data_q, word_data_d;
  logic [PACK-1:0]       word_strb_q, word_strb_d;
  logic                  word_valid_q, word_valid_d;

  logic                  accept;
  logic                  complete;
  logic signed [EW-1:0]  ext;
  logic signed [EW-1:0]  sh;
  logic [OUT_BITS-1:0]   quant;
  logic [WordW-1:0]      lane_buf;
  logic [PACK-1:0]       lane_strb;

  assign prod_ready_o = ~word_valid_q | word_ready_i;
  assign accept       = prod_valid_i & prod_ready_o;
  assign complete     = accept & ((cnt_q == CntW'(PACK - 1)) | last_i);

  assign word_valid_o = word_valid_q;
  assign word_data_o  = word_data_q;
  assign word_strb_o  = word_strb_q;

  // Extra sign bit keeps the rounding addition from overflowing.
  always_comb begin
    ext = signed'({product_i[PW-1], product_i});
`ifdef NEUREKA_NQ_ROUND_EN
    if (shift_i != 5'd0) begin
      ext = ext + signed'(EW'(1) << (shift_i - 5'd1));
    end
`endif
    sh = ext >>> shift_i;
  end

  always_comb begin
    quant = sh[OUT_BITS-1:0];
    if (signed_out_i) begin
      if (sh > SMax) begin
        quant = SMax[OUT_BITS-1:0];
      end else if (sh < SMin) begin
        quant = SMin[OUT_BITS-1:0];
      end
    end else begin
      if (sh < 0) begin
        quant = '0;
      end else if (sh > UMax) begin
        quant = UMax[OUT_BITS-1:0];
      end
    end
  end

  // Buffer and strobes with the current beat merged into lane cnt_q.
  always_comb begin
    lane_buf  = buf_q;
    lane_strb = strb_q;
    for (int i = 0; i < int'(PACK); i++) begin
      if (cnt_q == CntW'(i)) begin
        lane_buf[i*OUT_BITS +: OUT_BITS] = quant;
        lane_strb[i]                     = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    strb_d       = strb_q;
    word_data_d  = word_data_q;
    word_strb_d  = word_strb_q;
    word_valid_d = word_valid_q;
    if (clear_i) begin
      cnt_d        = '0;
      buf_d        = '0;
      strb_d       = '0;
      word_data_d  = '0;
      word_strb_d  = '0;
      word_valid_d = 1'b0;
    end else begin
      if (word_valid_q && word_ready_i) begin
        word_valid_d = 1'b0;
      end
      if (accept) begin
        if (complete) begin
          word_data_d  = lane_buf;
          word_strb_d  = lane_strb;
          word_valid_d = 1'b1;
          buf_d        = '0;
          strb_d       = '0;
          cnt_d        = '0;
        end else begin
          buf_d  = lane_buf;
          strb_d = lane_strb;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      buf_q        <= '0;
      strb_q       <= '0;
      word_data_q  <= '0;
      word_strb_q  <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      strb_q       <= strb_d;
      word_data_q  <= word_data_d;
      word_strb_q  <= word_strb_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule
